// File: rtl/serv_reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM states and reset-cause codes.
package serv_reset_pkg;

    typedef enum logic [1:0] {
        HOLD_ALL  = 2'd0,
        HOLD_CORE = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

endpackage

// File: rtl/serv_reset_seq_if.sv
// Reset request / reset output bundle between the sequencer and its environment.
interface serv_reset_seq_if;

    logic       i_ext_rst_n;
    logic       i_soft_rst;
    logic       o_periph_rst;
    logic       o_core_rst;
    logic       o_ready;
    logic [1:0] o_cause;

    modport slave (
        input  i_ext_rst_n,
        input  i_soft_rst,
        output o_periph_rst,
        output o_core_rst,
        output o_ready,
        output o_cause
    );

    modport master (
        output i_ext_rst_n,
        output i_soft_rst,
        input  o_periph_rst,
        input  o_core_rst,
        input  o_ready,
        input  o_cause
    );

endinterface

// File: rtl/serv_reset_seq_debounce.sv
// Button debouncer: 2-flop synchroniser followed by a W-bit stability counter.
// o_level is the debounced, active-low button level (1 = released).
module serv_debounce #(
    parameter int W = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_level
);

    logic         sync1_q, sync2_q;
    logic         level_q, level_d;
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (&cnt_q) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;

endmodule

// File: rtl/serv_reset_seq.sv
// Reset sequencer: merges generator, button and soft resets, releases peripherals
// before the core in counted order, and records the last reset cause.
module serv_reset_seq
    import serv_reset_pkg::*;
#(
    parameter int DEBOUNCE_W    = 16,
    parameter int PERIPH_CYCLES = 4,
    parameter int CORE_CYCLES   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    serv_reset_seq_if.slave  rst_bus
);

    localparam int MAX_CYCLES = (PERIPH_CYCLES > CORE_CYCLES) ? PERIPH_CYCLES : CORE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_CYCLES - 1);

    if (PERIPH_CYCLES < 1 || CORE_CYCLES < 1) begin : g_param_check
        $error("serv_reset_seq: PERIPH_CYCLES and CORE_CYCLES must both be >= 1");
    end

    logic             ext_level;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             periph_rst_q, periph_rst_d;
    logic             core_rst_q, core_rst_d;
    logic             ready_q, ready_d;

    serv_debounce #(.W(DEBOUNCE_W)) u_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn_n (rst_bus.i_ext_rst_n),
        .o_level (ext_level)
    );

    // A debounced button press beats everything, including a simultaneous soft request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        if (!ext_level) begin
            state_d = HOLD_ALL;
            cnt_d   = '0;
            cause_d = CAUSE_EXT;
        end else begin
            unique case (state_q)
                HOLD_ALL: begin
                    if (cnt_q == PERIPH_LAST) begin
                        state_d = HOLD_CORE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD_CORE: begin
                    if (cnt_q == CORE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (rst_bus.i_soft_rst) begin
                        state_d = HOLD_ALL;
                        cnt_d   = '0;
                        cause_d = CAUSE_SOFT;
                    end
                end
                default: begin
                    state_d = HOLD_ALL;
                    cnt_d   = '0;
                end
            endcase
        end
        periph_rst_d = (state_d == HOLD_ALL);
        core_rst_d   = (state_d != RUN);
        ready_d      = (state_d == RUN);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= HOLD_ALL;
            cnt_q        <= '0;
            cause_q      <= CAUSE_POR;
            periph_rst_q <= 1'b1;
            core_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            periph_rst_q <= periph_rst_d;
            core_rst_q   <= core_rst_d;
            ready_q      <= ready_d;
        end
    end

    assign rst_bus.o_periph_rst = periph_rst_q;
    assign rst_bus.o_core_rst   = core_rst_q;
    assign rst_bus.o_ready      = ready_q;
    assign rst_bus.o_cause      = cause_q;

endmodule
